// File: rtl/gate_test_sequencer_pkg.sv
// Shared types and constants for the gate test sequencer.
package gate_test_pkg;

    // Sequencer states, 2-bit encoding
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_CHECK  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // Truth tables, bit index = {A,B}
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_NAND = 4'b0111;

    // Width of the settle counter and the error counter
    localparam int CNT_W = 4;
    localparam int ERR_W = 3;

endpackage

// File: rtl/gate_test_sequencer_if.sv
// Bundles the run control, gate stimulus/response and result signals.
interface gate_test_sequencer_if;
    import gate_test_pkg::*;

    logic             start;
    logic             y;
    logic             a;
    logic             b;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] errCount;
    logic [3:0]       failVec;

    // The controlling side requests runs and returns the gate output
    modport master (
        output start, y,
        input  a, b, busy, done, pass, errCount, failVec
    );

    // The sequencer side drives the gate inputs and reports results
    modport slave (
        input  start, y,
        output a, b, busy, done, pass, errCount, failVec
    );

endinterface

// File: rtl/gate_test_sequencer_settle_counter.sv
// Loadable 4-bit down-counter that times how long each vector is held.
module settle_counter
    import gate_test_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_loadValue,
    input  logic             i_enable,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    // Load has priority over counting; the counter parks at zero
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_loadValue;
        end else if (i_enable && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/gate_test_sequencer.sv
// Walks a 2-input gate through 00,01,10,11 and checks it against a truth table.
module gate_test_sequencer
    import gate_test_pkg::*;
#(
    parameter logic [3:0] EXPECTED      = TT_AND,
    parameter int         SETTLE_CYCLES = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    gate_test_sequencer_if.slave bus
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_t           r_state;
    state_t           w_stateNext;
    logic [1:0]       r_idx;
    logic             r_a;
    logic             r_b;
    logic             r_pass;
    logic [ERR_W-1:0] r_errCount;
    logic [3:0]       r_failVec;

    logic             w_cntLoad;
    logic             w_cntEnable;
    logic             w_cntZero;
    logic             w_clear;
    logic             w_sample;
    logic             w_mismatch;
    logic [ERR_W-1:0] w_errNext;

    settle_counter u_settle (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_load      (w_cntLoad),
        .i_loadValue (RELOAD),
        .i_enable    (w_cntEnable),
        .o_zero      (w_cntZero)
    );

    // Compare Y with the table; an unknown Y falls into the mismatch branch
    always_comb begin
        w_mismatch = 1'b1;
        if (bus.y == EXPECTED[r_idx]) begin
            w_mismatch = 1'b0;
        end
        w_errNext = r_errCount + {{(ERR_W-1){1'b0}}, w_mismatch};
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state and control decode; START only matters in IDLE and DONE
    always_comb begin
        w_stateNext = r_state;
        w_cntLoad   = 1'b0;
        w_cntEnable = 1'b0;
        w_clear     = 1'b0;
        w_sample    = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    w_clear     = 1'b1;
                    w_cntLoad   = 1'b1;
                    w_stateNext = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (w_cntZero) begin
                    w_stateNext = S_CHECK;
                end else begin
                    w_cntEnable = 1'b1;
                end
            end
            S_CHECK: begin
                w_sample = 1'b1;
                if (r_idx == 2'd3) begin
                    w_stateNext = S_DONE;
                end else begin
                    w_cntLoad   = 1'b1;
                    w_stateNext = S_SETTLE;
                end
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    // Vector index, gate drive and result registers; all update on START or leaving CHECK
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_idx      <= 2'd0;
            r_a        <= 1'b0;
            r_b        <= 1'b0;
            r_pass     <= 1'b0;
            r_errCount <= '0;
            r_failVec  <= 4'd0;
        end else if (w_clear) begin
            r_idx      <= 2'd0;
            r_a        <= 1'b0;
            r_b        <= 1'b0;
            r_pass     <= 1'b0;
            r_errCount <= '0;
            r_failVec  <= 4'd0;
        end else if (w_sample) begin
            r_errCount <= w_errNext;
            if (w_mismatch) begin
                r_failVec[r_idx] <= 1'b1;
            end
            if (r_idx == 2'd3) begin
                r_a    <= 1'b0;
                r_b    <= 1'b0;
                r_pass <= (w_errNext == '0);
            end else begin
                r_idx      <= r_idx + 2'd1;
                {r_a, r_b} <= r_idx + 2'd1;
            end
        end
    end

    assign bus.a        = r_a;
    assign bus.b        = r_b;
    assign bus.busy     = (r_state == S_SETTLE) || (r_state == S_CHECK);
    assign bus.done     = (r_state == S_DONE);
    assign bus.pass     = r_pass;
    assign bus.errCount = r_errCount;
    assign bus.failVec  = r_failVec;

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Scoreboard bench: two sequencers (AND/settle 2 and XOR/settle 1) driving modelled gates.
module tb_gate_test_sequencer;
    import gate_test_pkg::*;

    typedef struct packed {
        logic [3:0] fv;
        logic [2:0] ec;
        logic       pass;
        int         doneEdge;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    gate_test_sequencer_if if0();
    gate_test_sequencer_if if1();

    gate_test_sequencer #(.EXPECTED(TT_AND), .SETTLE_CYCLES(2)) dut0 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (if0)
    );

    gate_test_sequencer #(.EXPECTED(TT_XOR), .SETTLE_CYCLES(1)) dut1 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (if1)
    );

    // Gate under test for each sequencer, modelled as its own truth table
    logic [3:0] gateTT [2];
    logic [3:0] expTT  [2];
    int         period [2];
    int         curAccept [2];
    bit         hasRun [2];
    logic       doneLast [2];
    exp_t       q0 [$];
    exp_t       q1 [$];

    int cycleCount  = 0;
    int assertCount = 0;
    int failCount   = 0;

    always_comb if0.y = gateTT[0][{if0.a, if0.b}];
    always_comb if1.y = gateTT[1][{if1.a, if1.b}];

    // Count rising edges so expectations can be stated in edge numbers
    always @(posedge clk) cycleCount <= cycleCount + 1;

    task automatic compare(input string name, input int act, input int req);
        assertCount++;
        if (act != req) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, act, req, cycleCount);
        end
    endtask

    function automatic logic getDone(input int w);
        return (w == 0) ? if0.done : if1.done;
    endfunction

    task automatic setStart(input int w, input logic v);
        if (w == 0) if0.start = v;
        else        if1.start = v;
    endtask

    // Expected results of one run: every differing table bit is a failing vector
    task automatic pushExpected(input int w);
        exp_t e;
        logic [3:0] fv;
        fv         = gateTT[w] ^ expTT[w];
        e.fv       = fv;
        e.ec       = 3'($countones(fv));
        e.pass     = (fv == 4'd0);
        e.doneEdge = curAccept[w] + 4 * period[w];
        if (w == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Per-cycle check against the timeline, plus scoreboard pop when DONE rises
    task automatic checkOutput(input int w, input logic a, input logic b, input logic busy,
                               input logic done, input logic pass, input logic [2:0] ec,
                               input logic [3:0] fv);
        int k;
        int p;
        int qs;
        exp_t e;
        logic expBusy;
        logic expDone;
        logic [1:0] expAB;
        p = period[w];
        if (!hasRun[w]) begin
            expBusy = 1'b0;
            expDone = 1'b0;
            expAB   = 2'd0;
            compare($sformatf("dut%0d_idle_ec", w), int'(ec), 0);
            compare($sformatf("dut%0d_idle_fv", w), int'(fv), 0);
            compare($sformatf("dut%0d_idle_pass", w), int'(pass), 0);
        end else begin
            k = cycleCount - curAccept[w];
            if (k < 4 * p) begin
                expBusy = 1'b1;
                expDone = 1'b0;
                expAB   = 2'(k / p);
            end else begin
                expBusy = 1'b0;
                expDone = 1'b1;
                expAB   = 2'd0;
            end
            if (k == 0) begin
                compare($sformatf("dut%0d_clear_ec", w), int'(ec), 0);
                compare($sformatf("dut%0d_clear_fv", w), int'(fv), 0);
                compare($sformatf("dut%0d_clear_pass", w), int'(pass), 0);
            end
        end
        compare($sformatf("dut%0d_ab", w), int'({a, b}), int'(expAB));
        compare($sformatf("dut%0d_busy", w), int'(busy), int'(expBusy));
        compare($sformatf("dut%0d_done", w), int'(done), int'(expDone));
        if (done && !doneLast[w]) begin
            qs = (w == 0) ? q0.size() : q1.size();
            compare($sformatf("dut%0d_sb_nonempty", w), int'(qs > 0), 1);
            if (qs > 0) begin
                e = (w == 0) ? q0.pop_front() : q1.pop_front();
                compare($sformatf("dut%0d_done_edge", w), cycleCount, e.doneEdge);
                compare($sformatf("dut%0d_fail_vec", w), int'(fv), int'(e.fv));
                compare($sformatf("dut%0d_err_count", w), int'(ec), int'(e.ec));
                compare($sformatf("dut%0d_pass", w), int'(pass), int'(e.pass));
            end
        end
        doneLast[w] = done;
    endtask

    // Monitor samples both sequencers on the falling edge
    always @(negedge clk) begin
        checkOutput(0, if0.a, if0.b, if0.busy, if0.done, if0.pass, if0.errCount, if0.failVec);
        checkOutput(1, if1.a, if1.b, if1.busy, if1.done, if1.pass, if1.errCount, if1.failVec);
    end

    task automatic waitDone(input int w);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (getDone(w)) begin
                seen = 1'b1;
                break;
            end
        end
        compare($sformatf("dut%0d_done_seen", w), int'(seen), 1);
    endtask

    // One run with a given gate; optionally START stays high into a restart
    task automatic applyStimulus(input int w, input logic [3:0] tt, input bit holdStart);
        @(negedge clk);
        #1;
        gateTT[w]    = tt;
        setStart(w, 1'b1);
        curAccept[w] = cycleCount + 1;
        hasRun[w]    = 1'b1;
        pushExpected(w);
        if (!holdStart) begin
            @(negedge clk);
            #1;
            setStart(w, 1'b0);
            waitDone(w);
        end else begin
            waitDone(w);
            #1;
            curAccept[w] = cycleCount + 1;
            pushExpected(w);
            @(negedge clk);
            #1;
            setStart(w, 1'b0);
            waitDone(w);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [3:0] tt;
        int w;
        gateTT[0] = TT_AND;
        gateTT[1] = TT_XOR;
        expTT[0]  = TT_AND;
        expTT[1]  = TT_XOR;
        period[0] = 3;
        period[1] = 2;
        for (int i = 0; i < 2; i++) begin
            hasRun[i]    = 1'b0;
            curAccept[i] = 0;
            doneLast[i]  = 1'b0;
        end
        if0.start = 1'b0;
        if1.start = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b1;
        $display("[TB] reset released");

        applyStimulus(0, TT_AND, 1'b0);
        applyStimulus(0, TT_OR, 1'b0);
        applyStimulus(0, 4'b1111, 1'b0);
        applyStimulus(0, 4'b1111, 1'b0);

        // Asynchronous reset during SETTLE of vector 10
        @(negedge clk);
        #1;
        gateTT[0]    = TT_AND;
        if0.start    = 1'b1;
        curAccept[0] = cycleCount + 1;
        hasRun[0]    = 1'b1;
        @(negedge clk);
        #1;
        if0.start = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        compare("pre_reset_ab", int'({if0.a, if0.b}), 2);
        rst_n     = 1'b0;
        hasRun[0] = 1'b0;
        hasRun[1] = 1'b0;
        #1;
        compare("async_rst_a", int'(if0.a), 0);
        compare("async_rst_b", int'(if0.b), 0);
        compare("async_rst_busy", int'(if0.busy), 0);
        compare("async_rst_done", int'(if0.done), 0);
        compare("async_rst_pass", int'(if0.pass), 0);
        compare("async_rst_ec", int'(if0.errCount), 0);
        compare("async_rst_fv", int'(if0.failVec), 0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        applyStimulus(0, TT_AND, 1'b0);
        applyStimulus(0, TT_AND, 1'b1);

        applyStimulus(1, TT_XOR, 1'b0);
        applyStimulus(1, TT_AND, 1'b0);

        // Randomized gates, sequencers and idle gaps
        for (int n = 0; n < 10; n++) begin
            w  = int'($urandom_range(0, 1));
            tt = 4'($urandom_range(0, 15));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            applyStimulus(w, tt, ($urandom_range(0, 3) == 0));
        end

        repeat (3) @(negedge clk);
        compare("sb0_drained", q0.size(), 0);
        compare("sb1_drained", q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/gate_test_sequencer.md
# gate_test_sequencer

Self-checking stimulus controller for a single 2-input combinational gate under test (AND/OR/XOR/NAND family). On START it drives the gate through all four input combinations in order 00, 01, 10, 11, waits a programmable settle time per vector, and compares the gate output against a parameterised truth table. It reports per-vector failures and a pass flag. It sits between the bench or top-level self-test and the gate instance, replacing hand-written `#10` stimulus sequences.

## Interface
- EXPECTED, 4'b1000: expected truth table; bit index = {A,B}; the default is AND.
- SETTLE_CYCLES, 2: cycles the inputs are held before Y is sampled; legal range 1..15.

- CLK  in  1  single clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- START  in  1  level-sampled run request; honoured only in IDLE or DONE.
- Y  in  1  output of the gate under test.
- A  out  1  gate input A; registered.
- B  out  1  gate input B; registered.
- BUSY  out  1  high in SETTLE and CHECK.
- DONE  out  1  high in DONE state.
- PASS  out  1  high in DONE when ERR_COUNT == 0; low otherwise.
- ERR_COUNT  out  3  mismatch count for the current or last run (0..4).
- FAIL_VEC  out  4  bit i is set when vector i = {A,B} mismatched.

## Operation
- States: IDLE, SETTLE, CHECK, DONE. Encoding is 2 bits.
- The 2-bit index idx selects the vector; A = idx[1], B = idx[0].
- IDLE/DONE with START=1:
  - idx←0, A←0, B←0.
  - ERR_COUNT←0, FAIL_VEC←0.
  - Settle counter←SETTLE_CYCLES-1.
  - Next state: SETTLE.
- SETTLE: the counter decrements each cycle. At 0, go to CHECK.
- CHECK (one cycle): Y is sampled at the edge leaving CHECK. A mismatch is Y ≠ EXPECTED[idx], and X/Z on Y counts as a mismatch. On a mismatch, ERR_COUNT+1 and FAIL_VEC[idx]←1.
  - If idx==3: A←0, B←0, go to DONE.
  - Otherwise: idx+1, A/B←new idx, reload the counter, go to SETTLE.
- DONE: holds all results until the next START. A START in DONE clears the results and restarts.
- START in SETTLE or CHECK is ignored.
- ERR_COUNT cannot overflow (max 4 with 3 bits).
- Reset (asynchronous, any state including mid-run): state→IDLE. A, B, BUSY, DONE, PASS, ERR_COUNT and FAIL_VEC all →0, and idx and the counter →0.

## Timing
- Each vector occupies SETTLE_CYCLES + 1 cycles: A/B are stable for that whole span, and Y is sampled at its final edge.
- Let the START-accepting edge be edge 0. DONE rises at edge 4·(SETTLE_CYCLES+1). With the default of 2, that is edge 12.
- BUSY rises at edge 0 and falls at the same edge DONE rises.
- PASS, DONE, ERR_COUNT and FAIL_VEC are all registered. They update on the edge leaving CHECK or entering DONE. There is no combinational path from Y to any output.
- A/B change only on edges leaving IDLE/DONE (to 00) or leaving CHECK. This gives the gate under test a full SETTLE window per vector.

## Structure
- Package gate_test_pkg holds:
  - the state enum/localparams (S_IDLE, S_SETTLE, S_CHECK, S_DONE);
  - truth-table constants TT_AND=4'b1000, TT_OR=4'b1110, TT_XOR=4'b0110, TT_NAND=4'b0111.
- One sub-module, settle_counter: a 4-bit loadable down-counter with load, enable and a zero flag. The FSM, index register and result registers live in gate_test_sequencer.

## Test plan
- Real AND gate, EXPECTED=TT_AND, SETTLE_CYCLES=2, START pulse:
  - A/B step 00,01,10,11, each held 3 cycles;
  - DONE at edge 12, PASS=1, ERR_COUNT=0, FAIL_VEC=0000.
- Y wired to an OR gate, EXPECTED=TT_AND → DONE with PASS=0, ERR_COUNT=2, FAIL_VEC=0110.
- Y tied to 1, EXPECTED=TT_AND → ERR_COUNT=3, FAIL_VEC=0111. Then a second START from DONE clears the results at edge 0, and BUSY=1 again.
- RST_N pulled low during the SETTLE of vector 10 → all outputs 0 immediately (asynchronously). A new START runs the full 4-vector sequence from 00.
- START held high continuously through a run → the run is not restarted mid-sequence. After DONE, the next edge restarts, so DONE is high for exactly 1 cycle.
- SETTLE_CYCLES=1, XOR gate with EXPECTED=TT_XOR → each vector is held 2 cycles, DONE at edge 8, PASS=1.
